// File: rtl/perf_mon_pkg.sv
// Shared types and default constants for the retirement performance monitor.
// Optional snapshot feature is enabled by the PERF_MON_SNAPSHOT_EN macro.
package perf_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_HALT    = 3'd2,
        ST_HANG    = 3'd3,
        ST_TIMEOUT = 3'd4
    } perf_state_e;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_PC_W        = 32;
    localparam int DEF_TIMEOUT_CYC = 100_000;
    localparam int DEF_HANG_CYC    = 1024;
    localparam int DEF_HALT_REPEAT = 4;

    function automatic logic is_terminal(perf_state_e s);
        return (s == ST_HALT) || (s == ST_HANG) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and hold.
// Clear has priority over hold, hold over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             hold,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (!hold && inc && (q != '1)) begin
            q_nxt = q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        q <= q_nxt;
    end

endmodule

// File: rtl/perf_monitor.sv
// Retirement monitor: saturating counters plus run/halt/hang/timeout FSM.
// Define PERF_MON_SNAPSHOT_EN to add the i_snap counter snapshot registers.
module perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PC_W        = DEF_PC_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HANG_CYC    = DEF_HANG_CYC,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_insn_vld,
    input  logic             i_ctrl,
    input  logic             i_mispred,
    input  logic [PC_W-1:0]  i_pc_debug,
    input  logic             i_clear,
`ifdef PERF_MON_SNAPSHOT_EN
    input  logic             i_snap,
    output logic [CNT_W-1:0] o_snap_insn,
    output logic [CNT_W-1:0] o_snap_mispred,
`endif
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_insn_cnt,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic             o_done,
    output logic             o_proto_err
);

    perf_state_e     state_q;
    perf_state_e     state_nxt;
    logic            clr;
    logic            terminal;
    logic            active;
    logic            vld_act;
    logic            ctrl_act;
    logic            mis_act;
    logic [31:0]     idle_q;
    logic [31:0]     idle_nxt;
    logic [31:0]     rep_q;
    logic [31:0]     rep_nxt;
    logic [PC_W-1:0] last_pc_q;
    logic            halt_hit;
    logic            hang_hit;
    logic            to_hit;
    logic            proto_q;

    assign clr      = ~i_reset | i_clear;
    assign terminal = is_terminal(state_q);
    // The IDLE->RUN entry cycle is counted like any RUN cycle.
    assign active   = (state_q == ST_RUN) |
                      ((state_q == ST_IDLE) & i_insn_vld);
    assign vld_act  = active & i_insn_vld;
    assign ctrl_act = vld_act & i_ctrl;
    assign mis_act  = ctrl_act & i_mispred;

    sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk  (i_clk),
        .clr  (clr),
        .hold (terminal),
        .inc  (active),
        .q    (o_cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_insn (
        .clk  (i_clk),
        .clr  (clr),
        .hold (terminal),
        .inc  (vld_act),
        .q    (o_insn_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ctrl (
        .clk  (i_clk),
        .clr  (clr),
        .hold (terminal),
        .inc  (ctrl_act),
        .q    (o_ctrl_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred (
        .clk  (i_clk),
        .clr  (clr),
        .hold (terminal),
        .inc  (mis_act),
        .q    (o_mispred_cnt)
    );

    always_comb begin
        idle_nxt = i_insn_vld ? 32'd0 : idle_q + 32'd1;
        rep_nxt  = (i_pc_debug == last_pc_q) ? rep_q + 32'd1 : 32'd1;
    end

    assign halt_hit = vld_act & (rep_nxt == 32'(HALT_REPEAT));
    assign hang_hit = active & (HANG_CYC != 0) &
                      (idle_nxt == 32'(HANG_CYC));
    // Timeout fires on the edge the cycle count becomes TIMEOUT_CYC.
    assign to_hit   = active & (TIMEOUT_CYC != 0) &
                      (o_cycle_cnt != '1) &
                      ((64'(o_cycle_cnt) + 64'd1) == 64'(TIMEOUT_CYC));

    always_ff @(posedge i_clk) begin
        if (clr) begin
            idle_q    <= '0;
            rep_q     <= '0;
            last_pc_q <= '0;
        end else if (active) begin
            idle_q <= idle_nxt;
            if (i_insn_vld) begin
                rep_q     <= rep_nxt;
                last_pc_q <= i_pc_debug;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            proto_q <= 1'b0;
        end else if (i_insn_vld & i_mispred & ~i_ctrl) begin
            proto_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (i_clear) begin
            state_nxt = ST_IDLE;
        end else if (active) begin
            if (halt_hit) begin
                state_nxt = ST_HALT;
            end else if (hang_hit) begin
                state_nxt = ST_HANG;
            end else if (to_hit) begin
                state_nxt = ST_TIMEOUT;
            end else begin
                state_nxt = ST_RUN;
            end
        end
    end

    always_comb begin
        o_state     = state_q;
        o_done      = terminal;
        o_proto_err = proto_q;
    end

`ifdef PERF_MON_SNAPSHOT_EN
    logic [CNT_W-1:0] snap_insn_nxt;
    logic [CNT_W-1:0] snap_mis_nxt;

    // Snapshot captures the post-update counter values of this edge.
    always_comb begin
        snap_insn_nxt = o_insn_cnt;
        snap_mis_nxt  = o_mispred_cnt;
        if (!terminal && vld_act && (o_insn_cnt != '1)) begin
            snap_insn_nxt = o_insn_cnt + CNT_W'(1);
        end
        if (!terminal && mis_act && (o_mispred_cnt != '1)) begin
            snap_mis_nxt = o_mispred_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            o_snap_insn    <= '0;
            o_snap_mispred <= '0;
        end else if (i_snap) begin
            o_snap_insn    <= snap_insn_nxt;
            o_snap_mispred <= snap_mis_nxt;
        end
    end
`endif

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable retirement monitor for the pipelined RV32I core with branch prediction. It samples the core debug outputs (instruction-valid, control-transfer, mispredict, PC) and maintains saturating cycle, instruction, control and mispredict counters. A state machine detects run start, self-loop halt, hang (no retirement) and global timeout. It serves both the simulation scoreboard and the FPGA top, where the counters drive the LCD/HEX path.

## Interface
Parameters:
- CNT_W, 32: width of every counter; counters saturate at 2^CNT_W-1
- PC_W, 32: width of sampled PC
- TIMEOUT_CYC, 100_000: cycles in RUN before TIMEOUT; 0 disables
- HANG_CYC, 1024: consecutive cycles in RUN without i_insn_vld before HANG; 0 disables
- HALT_REPEAT, 4: consecutive valid retirements at identical PC before HALT; must be ≥2

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_insn_vld  in  1  one instruction retired this cycle
- i_ctrl  in  1  retired instruction is a branch/jump (qualified by i_insn_vld)
- i_mispred  in  1  retired control instruction was mispredicted (qualified by i_insn_vld & i_ctrl)
- i_pc_debug  in  PC_W  PC of retired instruction
- i_clear  in  1  synchronous soft clear
- o_state  out  3  state encoding (package enum)
- o_cycle_cnt / o_insn_cnt / o_ctrl_cnt / o_mispred_cnt  out  CNT_W each  counters
- o_done  out  1  state is HALT, HANG or TIMEOUT
- o_proto_err  out  1  sticky: i_insn_vld & i_mispred & !i_ctrl seen

## Operation
- States: IDLE(0), RUN(1), HALT(2), HANG(3), TIMEOUT(4).
- IDLE→RUN on first cycle with i_insn_vld=1; that retirement is counted.
- RUN: o_cycle_cnt +1 every cycle (including entry cycle); o_insn_cnt +1 on i_insn_vld; o_ctrl_cnt +1 on i_insn_vld&i_ctrl; o_mispred_cnt +1 on i_insn_vld&i_ctrl&i_mispred.
- Idle counter: cleared on i_insn_vld, else +1; reaching HANG_CYC → HANG.
- Repeat counter: on i_insn_vld, +1 if i_pc_debug equals last valid PC, else reset to 1; reaching HALT_REPEAT → HALT.
- Cycle counter reaching TIMEOUT_CYC → TIMEOUT.
- Priority in same cycle: HALT > HANG > TIMEOUT.
- HALT/HANG/TIMEOUT are terminal: all counters frozen, inputs ignored (except o_proto_err) until i_clear or reset.
- Counters saturate; no wrap. Saturation does not change state.
- i_clear: counters, idle/repeat counters, last PC, o_proto_err → 0, state → IDLE; i_clear beats any same-cycle event (event not counted).
- Reset: identical to i_clear, regardless of state.

## Timing
- Reset values: o_state=IDLE, all counters 0, o_done=0, o_proto_err=0.
- All outputs registered; an input event sampled at edge N is visible at outputs after edge N.
- Transition to terminal state and o_done assert on the same edge as the triggering count update.
- o_done is a pure decode of the state register (no extra latency).
- No handshake; inputs are single-cycle strobes, one retirement per cycle max.

## Configuration
- Macro PERF_MON_SNAPSHOT_EN.
- Defined: extra input i_snap (1b) and outputs o_snap_insn, o_snap_mispred (CNT_W); on i_snap=1 both registers latch the counter values present *after* that edge's update. Snapshot registers clear on reset/i_clear only; i_clear wins over i_snap.
- Undefined: no snapshot ports or registers.

## Structure
- Package perf_mon_pkg: state enum perf_state_e (3 bits, values above), default parameter constants.
- One sub-module: sat_counter (CNT_W parameter; inc, clr, hold inputs), instantiated four times; idle/repeat counters inline.

## Test plan
- Reset held 25 cycles, then released with inputs 0 → o_state=IDLE, all counters 0, o_done=0 for 50 cycles.
- 10 retirements at PCs 0x0,0x4,…,0x24, 3 with ctrl, 1 with mispred → insn=10, ctrl=3, mispred=1, state RUN.
- 4 retirements at PC 0x40 (HALT_REPEAT=4) → HALT on 4th, o_done=1; further strobes leave counters unchanged.
- RUN then no i_insn_vld for 1024 cycles → HANG on cycle 1024; i_clear → IDLE, all 0.
- TIMEOUT_CYC=100, retire every cycle at incrementing PCs → TIMEOUT with cycle_cnt=100; CNT_W=4 run → insn_cnt saturates at 15.
- i_insn_vld&i_mispred&!i_ctrl → o_proto_err=1, mispred_cnt unchanged; i_clear with simultaneous i_insn_vld → all counters 0, IDLE.
